// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for RAM controllers: FSM state encodings and port indices.
package ram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } ram_state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-port round-robin arbiter, purely combinational; the caller owns last_grant.
module rr_arb2
  import ram_ctrl_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant,
  output logic valid
);

  always_comb begin
    grant = PORT0;
    valid = req0 | req1;
    // On contention the port that did not win last time gets the slot.
    if (req0 && req1) begin
      grant = (last_grant == PORT0) ? PORT1 : PORT0;
    end else if (req1) begin
      grant = PORT1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Dual-port front end for a single-port RAM: zero-fill sweep after reset, then
// round-robin arbitrated accesses taking IDLE -> ACCESS -> RESP (3 cycles each).
module ram_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int SEL_WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [SEL_WIDTH-1:0] addr0,
  input  logic [SEL_WIDTH-1:0] addr1,
  input  logic [BIT_WIDTH-1:0] wdata0,
  input  logic [BIT_WIDTH-1:0] wdata1,
  output logic                 ack0,
  output logic                 ack1,
  output logic [BIT_WIDTH-1:0] rdata0,
  output logic [BIT_WIDTH-1:0] rdata1,
  output logic                 ready,
  output logic [SEL_WIDTH-1:0] ram_address,
  output logic [BIT_WIDTH-1:0] ram_in,
  output logic                 ram_load,
  input  logic [BIT_WIDTH-1:0] ram_rdata
);

  localparam int DEPTH = 2 ** SEL_WIDTH;
  // Counter is one bit wider than the address so the final sweep value is distinct.
  localparam logic [SEL_WIDTH:0] LAST_ADDR = (SEL_WIDTH + 1)'(DEPTH - 1);

  ram_state_e           state_q, state_d;
  logic [SEL_WIDTH:0]   cnt_q, cnt_d;
  logic                 last_grant_q, last_grant_d;
  logic                 grant_q, grant_d;
  logic [BIT_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [BIT_WIDTH-1:0] rdata1_q, rdata1_d;

  logic                 arb_grant;
  logic                 arb_valid;
  logic                 g_we;
  logic [SEL_WIDTH-1:0] g_addr;
  logic [BIT_WIDTH-1:0] g_wdata;

  rr_arb2 u_arb (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .valid      (arb_valid)
  );

  assign g_we    = (grant_q == PORT1) ? we1    : we0;
  assign g_addr  = (grant_q == PORT1) ? addr1  : addr0;
  assign g_wdata = (grant_q == PORT1) ? wdata1 : wdata0;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    ram_address  = '0;
    ram_in       = '0;
    ram_load     = 1'b0;
    ack0         = 1'b0;
    ack1         = 1'b0;
    ready        = 1'b0;
    case (state_q)
      ST_INIT: begin
        ram_load    = 1'b1;
        ram_address = cnt_q[SEL_WIDTH-1:0];
        cnt_d       = cnt_q + (SEL_WIDTH + 1)'(1);
        if (cnt_q == LAST_ADDR) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        ready = 1'b1;
        if (arb_valid) begin
          grant_d = arb_grant;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        ram_address  = g_addr;
        ram_load     = g_we;
        ram_in       = g_wdata;
        last_grant_d = grant_q;
        if (!g_we) begin
          if (grant_q == PORT1) rdata1_d = ram_rdata;
          else                  rdata0_d = ram_rdata;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        ack0    = (grant_q == PORT0);
        ack1    = (grant_q == PORT1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      last_grant_q <= PORT1;
      grant_q      <= PORT0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: behavioural RAM, vector table of port accesses,
// plus hand sequences for init sweep, contention and reset during an access.
module tb_ram_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [3:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1, ready, ram_load;
  logic [15:0] rdata0, rdata1, ram_in, ram_rdata;
  logic [3:0]  ram_address;
  logic        poison;
  logic [15:0] mem [16];

  int errors = 0;
  int checks = 0;

  ram_arbiter #(.BIT_WIDTH(16), .SEL_WIDTH(4)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .ready(ready), .ram_address(ram_address), .ram_in(ram_in),
    .ram_load(ram_load), .ram_rdata(ram_rdata)
  );

  always #5 clock = ~clock;

  // External RAM; poison fills it with a non-zero pattern so the sweep is observable.
  always @(posedge clock) begin
    if (poison) begin
      for (int k = 0; k < 16; k++) mem[k] <= 16'hDEAD;
    end else if (ram_load) begin
      mem[ram_address] <= ram_in;
    end
  end
  assign ram_rdata = mem[ram_address];

  typedef struct {
    bit          port;
    bit          we;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!ready && n < 64) begin
      @(posedge clock); @(negedge clock); n++;
    end
    check({name, "_ready"}, 32'(ready), 32'd1);
  endtask

  task automatic do_txn(input bit p, input bit we, input logic [3:0] a,
                        input logic [15:0] wd, input logic [15:0] exp, input string name);
    int  lat = 0;
    bit  got = 0;
    bit  other = 0;
    wait_ready(name);
    if (p) begin req1 = 1; we1 = we; addr1 = a; wdata1 = wd; end
    else   begin req0 = 1; we0 = we; addr0 = a; wdata0 = wd; end
    while (!got && lat < 10) begin
      @(posedge clock); @(negedge clock); lat++;
      if ((p ? ack0 : ack1) === 1'b1) other = 1;
      if ((p ? ack1 : ack0) === 1'b1) got = 1;
    end
    check({name, "_latency"}, got ? 32'(lat) : 32'hFFFF, 32'd2);
    check({name, "_other_ack"}, 32'(other), 32'd0);
    if (!we) check({name, "_rdata"}, 32'(p ? rdata1 : rdata0), 32'(exp));
    req0 = 0; req1 = 0;
    @(negedge clock);
    check({name, "_ack_single"}, 32'(p ? ack1 : ack0), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int order [4];
    int nack;
    bit both;
    bit seen;

    vecs[0] = '{1'b0, 1'b1, 4'd3,  16'h000A, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 4'd3,  16'h0000, 16'h000A};
    vecs[2] = '{1'b1, 1'b1, 4'd15, 16'h000F, 16'h0000};
    vecs[3] = '{1'b0, 1'b0, 4'd15, 16'h0000, 16'h000F};
    vecs[4] = '{1'b1, 1'b0, 4'd0,  16'h0000, 16'h0000};
    vecs[5] = '{1'b1, 1'b1, 4'd3,  16'h0005, 16'h0000};
    vecs[6] = '{1'b0, 1'b0, 4'd3,  16'h0000, 16'h0005};

    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    reset = 0; poison = 1;

    // Asynchronous reset: outputs settle before any clock edge.
    #2 reset = 1;
    #1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_ack0", 32'(ack0), 32'd0);
    check("rst_ack1", 32'(ack1), 32'd0);
    check("rst_rdata0", 32'(rdata0), 32'd0);
    check("rst_rdata1", 32'(rdata1), 32'd0);
    @(negedge clock); @(negedge clock);
    poison = 0;
    check("rst_ram_load", 32'(ram_load), 32'd1);
    @(negedge clock);
    reset = 0;

    // Init sweep length and contents.
    cnt = 0;
    while (!ready && cnt < 100) begin
      @(posedge clock); @(negedge clock); cnt++;
    end
    check("init_len", 32'(cnt), 32'd16);
    for (int i = 0; i < 16; i++) do_txn(1'(i % 2), 1'b0, 4'(i), 16'h0, 16'h0, "init_rd");

    // Contention: both ports write continuously; grants alternate starting at port 0.
    wait_ready("cont");
    req0 = 1; we0 = 1; addr0 = 4'd1; wdata0 = 16'h0011;
    req1 = 1; we1 = 1; addr1 = 4'd2; wdata1 = 16'h0022;
    nack = 0; both = 0; cnt = 0;
    while (nack < 4 && cnt < 40) begin
      @(posedge clock); @(negedge clock); cnt++;
      if (ack0 && ack1) both = 1;
      if (ack0) begin order[nack] = 0; nack++; end
      else if (ack1) begin order[nack] = 1; nack++; end
    end
    req0 = 0; req1 = 0;
    check("cont_nack", 32'(nack), 32'd4);
    check("cont_both_ack", 32'(both), 32'd0);
    for (int i = 0; i < 4; i++) check("cont_order", (i < nack) ? 32'(order[i]) : 32'hFFFF, 32'(i % 2));
    do_txn(1'b1, 1'b0, 4'd1, 16'h0, 16'h0011, "cont_rd1");
    do_txn(1'b1, 1'b0, 4'd2, 16'h0, 16'h0022, "cont_rd2");

    // Vector table: write/read, wrap address, overwrite.
    for (int i = 0; i < 7; i++)
      do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp, "vec");

    // Reset during the ACCESS cycle of a write: transaction is dropped.
    wait_ready("rmid");
    req0 = 1; we0 = 1; addr0 = 4'd5; wdata0 = 16'h0007;
    @(posedge clock); @(negedge clock);
    reset = 1;
    req0 = 0; we0 = 0;
    #1;
    check("rmid_ack0", 32'(ack0), 32'd0);
    check("rmid_ready", 32'(ready), 32'd0);
    check("rmid_rdata0", 32'(rdata0), 32'd0);
    check("rmid_addr", 32'(ram_address), 32'd0);
    @(negedge clock); @(negedge clock);
    reset = 0;
    cnt = 0; seen = 0;
    while (!ready && cnt < 100) begin
      @(posedge clock); @(negedge clock); cnt++;
      if (ack0 || ack1) seen = 1;
    end
    check("rmid_init_len", 32'(cnt), 32'd16);
    check("rmid_no_ack", 32'(seen), 32'd0);
    do_txn(1'b0, 1'b0, 4'd5, 16'h0, 16'h0, "rmid_rd5");
    do_txn(1'b1, 1'b0, 4'd15, 16'h0, 16'h0, "rmid_rd15");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter BIT_WIDTH, default 16, data word width in bits.
REQ-002 Parameter SEL_WIDTH, default 4, address width; RAM depth N = 2**SEL_WIDTH.
REQ-003 One clock; reset is asynchronous and active-high; ports named clock and reset.
REQ-004 Port list (name, direction, width, meaning):
- clock in 1: rising-edge clock.
- reset in 1: async active-high reset.
- req0 / req1 in 1: access request, ports 0 and 1.
- we0 / we1 in 1: 1 = write, 0 = read.
- addr0 / addr1 in SEL_WIDTH: word address.
- wdata0 / wdata1 in BIT_WIDTH: write data.
- ack0 / ack1 out 1: one-cycle completion pulse.
- rdata0 / rdata1 out BIT_WIDTH: read data, valid while the matching ack is high.
- ready out 1: controller is in IDLE.
- ram_address out SEL_WIDTH: RAM address.
- ram_in out BIT_WIDTH: RAM write data.
- ram_load out 1: RAM write enable.
- ram_rdata in BIT_WIDTH: RAM word at ram_address (externally muxed).

Function
REQ-005 FSM states are INIT, IDLE, ACCESS and RESP; there are no other states.
REQ-006 INIT behaviour:
- sweep counter runs 0..N-1, one address per cycle;
- ram_load=1, ram_in=0, ram_address=counter;
- after address N-1 is written the FSM moves to IDLE;
- INIT lasts exactly N cycles.
REQ-007 Requests arriving during INIT, ACCESS or RESP are not accepted; no ack is produced for them until they are accepted in IDLE.
REQ-008 IDLE arbitration: with exactly one req high, that port is granted; with both high, the port opposite last_grant wins (round-robin); the FSM then moves to ACCESS.
REQ-009 IDLE with no req stays in IDLE, with ram_load=0.
REQ-010 ACCESS lasts one cycle:
- ram_address = granted addr;
- ram_load = granted we; ram_in = granted wdata;
- on a read, ram_rdata is registered at the end of the cycle;
- last_grant is updated to the granted port;
- FSM moves to RESP.
REQ-011 RESP lasts one cycle:
- granted port's ack=1;
- for a read, rdata holds the captured word; for a write, rdata is unchanged;
- ram_load=0; FSM moves to IDLE.
REQ-012 The requester holds req, we, addr and wdata stable from assertion until the cycle its ack is seen. Request signals are sampled only in IDLE and ACCESS.
REQ-013 Throughput is one access per 3 cycles. A request held continuously is granted within 6 cycles of IDLE entry, so there is no starvation.
REQ-014 At most one ack is high in any cycle; ack is never high outside RESP.
REQ-015 Address wrap: address N-1 is a legal target. The sweep counter is SEL_WIDTH+1 bits wide, so its termination does not alias to 0.
REQ-016 ram_load is high only in INIT, and in ACCESS when the granted we=1.

Reset
REQ-017 Asserting reset immediately forces:
- state=INIT, sweep counter=0, last_grant=1;
- ack0=ack1=0, rdata0=rdata1=0, ready=0.
REQ-018 Reset mid-ACCESS or mid-RESP discards the transaction with no ack; the sweep restarts from 0 after reset deasserts.
REQ-019 ram_load may be 1 during reset (INIT, writing 0); this is the intended behaviour.

Structure
REQ-020 State encodings (2-bit) and the port-index constants live in a shared package, ram_ctrl_pkg, for reuse by future RAM controllers.
REQ-021 Arbitration is a sub-module, rr_arb2:
- inputs: req0, req1, last_grant;
- output: grant index and valid;
- purely combinational; the last_grant register stays in ram_arbiter.
REQ-022 The RAM itself is outside this block; the top level connects ram_* to the RAM instance.

Verification
REQ-023 Init sweep: reset pulse, SEL_WIDTH=4 -> ready rises exactly 16 cycles after reset deasserts; all 16 words read back 0.
REQ-024 Write then read: port0 writes addr=3, data=0xA -> ack0 in the 3rd cycle after req accept. Port0 then reads addr=3 -> rdata0=0xA with ack1 never high.
REQ-025 Contention: req0 and req1 both held through 4 transactions -> ack order is 0,1,0,1; each write lands at its own address.
REQ-026 Reset mid-op: reset asserted during ACCESS of a write to addr=5, data=0x7 -> no ack; addr 5 reads 0 after re-init.
REQ-027 Wrap and hold: port1 writes addr=15, data=0xF while req0 is held low -> ack1 pulses once; reads of addr 15 return 0xF and addr 0 returns 0.
